// File: rtl/jt900h_pfq_pkg.sv
// Shared constants for the JT900H prefetch queue: bus FSM state codes,
// byte-lane geometry and small helpers used by the top and the ring.
package jt900h_pfq_pkg;

  // Bus FSM state codes
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPfetch  = 2'd1;
  localparam logic [1:0] StDread   = 2'd2;
  localparam logic [1:0] StDiscard = 2'd3;

  // Byte-lane geometry
  localparam int unsigned ByteW    = 8;
  localparam int unsigned WordW    = 16;
  localparam int unsigned WinBytes = 4;

  // Bytes a prefetch will push: an odd fetch address only yields the high byte
  function automatic logic [1:0] fetch_need(input logic odd);
    return odd ? 2'd1 : 2'd2;
  endfunction

  // Saturating 16-bit increment for the statistics counters
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/jt900h_pfq_ring.sv
// DEPTH x 8 byte ring for the prefetch queue. Accepts 0/1/2 bytes per cycle at
// the tail, releases 0-4 bytes at the head and exposes a 4-byte head window with
// invalid lanes forced to zero. fill_nxt lets the owner plan bus issues against
// the occupancy the ring will have after this cycle.
module jt900h_pfq_ring
  import jt900h_pfq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      clr,
  input  logic [1:0]                wr_cnt,
  input  logic [WordW-1:0]          wr_data,
  input  logic [2:0]                rd_cnt,
  output logic [ByteW*WinBytes-1:0] win,
  output logic [2:0]                win_cnt,
  output logic [PW:0]               fill,
  output logic [PW:0]               fill_nxt
);

  logic [ByteW-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      fill_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    wr_ptr1;

  // Tail sits fill bytes past the head; wraps naturally at PW bits
  assign wr_ptr  = rd_ptr_q + fill_q[PW-1:0];
  assign wr_ptr1 = wr_ptr + PW'(1);

  // Occupancy after this cycle's push/pop (or flush)
  always_comb begin
    fill_nxt = fill_q + (PW+1)'(wr_cnt) - (PW+1)'(rd_cnt);
    if (clr) fill_nxt = '0;
  end

  // Head pointer and fill count
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else if (cen) begin
      fill_q   <= fill_nxt;
      rd_ptr_q <= clr ? '0 : rd_ptr_q + PW'(rd_cnt);
    end
  end

  // Byte storage; tail slots are always free because the owner checks space
  always_ff @(posedge clk) begin
    if (!rst && cen && !clr) begin
      if (wr_cnt != 2'd0) mem[wr_ptr]  <= wr_data[ByteW-1:0];
      if (wr_cnt == 2'd2) mem[wr_ptr1] <= wr_data[WordW-1:ByteW];
    end
  end

  // Head window, lanes beyond the fill level read as zero
  always_comb begin
    win = '0;
    for (int i = 0; i < WinBytes; i++) begin
      if (fill_q > (PW+1)'(i)) win[ByteW*i +: ByteW] = mem[rd_ptr_q + PW'(i)];
    end
  end

  assign win_cnt = (fill_q >= (PW+1)'(WinBytes)) ? 3'd4 : 3'(fill_q);
  assign fill    = fill_q;

endmodule

// File: rtl/jt900h_pfq.sv
// JT900H prefetch queue and bus arbiter. Streams little-endian 16-bit words
// into a byte ring, shows up to four head bytes to the decoder, flushes on
// jumps and lets operand reads take the bus whenever it is idle.
// Optional build macro JT900H_PFQ_STATS_EN adds stall_cnt/flush_cnt counters.
module jt900h_pfq
  import jt900h_pfq_pkg::*;
#(
  parameter int unsigned   DEPTH = 8,
  parameter int unsigned   AW    = 24,
  parameter logic [AW-1:0] RSTPC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              jmp_en,
  input  logic [AW-1:0]     jmp_addr,
  input  logic [2:0]        pop,
  output logic [31:0]       op,
  output logic [2:0]        op_cnt,
  output logic [AW-1:0]     pc,
  output logic              pop_err,
`ifdef JT900H_PFQ_STATS_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  input  logic              data_req,
  input  logic [AW-1:0]     data_addr,
  output logic [WordW-1:0]  data_dout,
  output logic              data_ok,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_cs,
  input  logic [WordW-1:0]  ram_dout,
  input  logic              ram_ok
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [1:0]       st_q, st_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    faddr_q, faddr_d;
  logic [AW-1:0]    bus_addr_q, bus_addr_d;
  logic             pop_err_q;
  logic             data_ok_q;
  logic [WordW-1:0] data_dout_q;

  logic             pop_ok;
  logic             push;
  logic [1:0]       push_cnt;
  logic [WordW-1:0] wr_data;
  logic [2:0]       rd_cnt;
  logic [31:0]      win;
  logic [2:0]       win_cnt;
  logic [PW:0]      fill;
  logic [PW:0]      fill_nxt;
  logic [PW:0]      space;
  logic             can_fetch;

  // A pop larger than the visible head is rejected wholesale
  assign pop_ok   = (pop <= win_cnt);
  // A jump drops whatever arrives this cycle
  assign push     = (st_q == StPfetch) && ram_ok && !jmp_en;
  assign push_cnt = push ? fetch_need(faddr_q[0]) : 2'd0;
  assign wr_data  = faddr_q[0] ? {8'h00, ram_dout[WordW-1:ByteW]} : ram_dout;
  assign rd_cnt   = (!jmp_en && pop_ok) ? pop : 3'd0;

  jt900h_pfq_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .clr      (jmp_en),
    .wr_cnt   (push_cnt),
    .wr_data  (wr_data),
    .rd_cnt   (rd_cnt),
    .win      (win),
    .win_cnt  (win_cnt),
    .fill     (fill),
    .fill_nxt (fill_nxt)
  );

  // Program counter and fetch address; jump overrides pop and push
  always_comb begin
    pc_d    = pc_q + AW'(rd_cnt);
    faddr_d = faddr_q + AW'(push_cnt);
    if (jmp_en) begin
      pc_d    = jmp_addr;
      faddr_d = jmp_addr;
    end
  end

  // Issue a prefetch only if the post-cycle ring has room for what it returns
  always_comb begin
    space     = (PW+1)'(DEPTH) - fill_nxt;
    can_fetch = (space >= (PW+1)'(fetch_need(faddr_d[0])));
  end

  // Bus FSM: operand reads win only from idle; bus address latched at issue
  always_comb begin
    st_d       = st_q;
    bus_addr_d = bus_addr_q;
    case (st_q)
      StIdle: begin
        // data_ok_q still high means the requester has not yet dropped data_req
        if (data_req && !data_ok_q) begin
          st_d       = StDread;
          bus_addr_d = data_addr & ~AW'(1);
        end else if (can_fetch) begin
          st_d       = StPfetch;
          bus_addr_d = faddr_d & ~AW'(1);
        end
      end
      StPfetch: begin
        if (ram_ok)      st_d = StIdle;
        else if (jmp_en) st_d = StDiscard;
      end
      default: begin
        if (ram_ok) st_d = StIdle;
      end
    endcase
  end

  // Architectural state
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      pc_q        <= RSTPC;
      faddr_q     <= RSTPC;
      bus_addr_q  <= RSTPC & ~AW'(1);
      pop_err_q   <= 1'b0;
      data_ok_q   <= 1'b0;
      data_dout_q <= '0;
    end else if (cen) begin
      st_q       <= st_d;
      pc_q       <= pc_d;
      faddr_q    <= faddr_d;
      bus_addr_q <= bus_addr_d;
      if (!pop_ok) pop_err_q <= 1'b1;
      data_ok_q  <= (st_q == StDread) && ram_ok;
      if ((st_q == StDread) && ram_ok) data_dout_q <= ram_dout;
    end
  end

  assign op        = win;
  assign op_cnt    = win_cnt;
  assign pc        = pc_q;
  assign pop_err   = pop_err_q;
  assign data_dout = data_dout_q;
  assign data_ok   = data_ok_q;
  assign ram_addr  = bus_addr_q;
  assign ram_cs    = (st_q != StIdle);

`ifdef JT900H_PFQ_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Decoder starved while the bus serves an operand read; jumps taken
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (cen) begin
      if ((win_cnt < 3'd4) && (st_q == StDread)) stall_q <= sat_inc(stall_q);
      if (jmp_en) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_fill;
  assign unused_fill = ^fill;
`endif

endmodule

// File: tb/tb_jt900h_pfq.sv
// Bench for jt900h_pfq: a byte-queue model of the prefetch stream plus a
// transaction-level view of the bus, compared against the DUT every cycle,
// with directed scenarios and literal expectations around them.
module tb_jt900h_pfq;

  localparam int DEPTH = 8;
  localparam int KIdle = 0, KFetch = 1, KData = 2, KDisc = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        jmp_en = 1'b0;
  logic [23:0] jmp_addr = '0;
  logic [2:0]  pop = '0;
  logic        data_req = 1'b0;
  logic [23:0] data_addr = '0;
  logic [15:0] ram_dout = '0;
  logic        ram_ok = 1'b0;
  logic [31:0] op;
  logic [2:0]  op_cnt;
  logic [23:0] pc;
  logic        pop_err;
  logic [15:0] data_dout;
  logic        data_ok;
  logic [23:0] ram_addr;
  logic        ram_cs;
`ifdef JT900H_PFQ_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  jt900h_pfq #(
    .DEPTH (DEPTH),
    .AW    (24),
    .RSTPC (24'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .pop       (pop),
    .op        (op),
    .op_cnt    (op_cnt),
    .pc        (pc),
    .pop_err   (pop_err),
`ifdef JT900H_PFQ_STATS_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .data_req  (data_req),
    .data_addr (data_addr),
    .data_dout (data_dout),
    .data_ok   (data_ok),
    .ram_addr  (ram_addr),
    .ram_cs    (ram_cs),
    .ram_dout  (ram_dout),
    .ram_ok    (ram_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs
  int cen_pct = 100, lat_min = 0, lat_max = 0, jmp_pct = 0, dreq_pct = 0, bad_pct = 0;
  int pop_mode = 0;
  int f_pop = -1;
  bit f_jmp = 0, f_dreq = 0;
  logic [23:0] f_jaddr = '0, f_daddr = '0;
  int wait_cnt = 0;

  // Model: bytes queued from pc onward, plus the bus transaction in progress
  logic [7:0]  q[$];
  logic [23:0] m_pc, m_faddr, m_bus;
  int          m_k;
  bit          m_err, m_dok;
  logic [15:0] m_dout;

  function automatic logic [7:0] mbyte(input logic [23:0] a);
    logic [7:0] s;
    s = a[7:0] + 8'd1;
    return 8'(s * 8'h11) ^ a[15:8] ^ a[23:16];
  endfunction

  function automatic logic [15:0] mword(input logic [23:0] a);
    return {mbyte({a[23:1], 1'b1}), mbyte({a[23:1], 1'b0})};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int head_cnt();
    return (q.size() > 4) ? 4 : q.size();
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = 24'h0; m_faddr = 24'h0; m_bus = 24'h0;
    m_k = KIdle; m_err = 0; m_dok = 0; m_dout = 16'h0;
  endtask

  // Per-cycle comparison of every meaningful output against the model
  task automatic compare();
    logic [31:0] e;
    int cnt;
    cnt = head_cnt();
    e = '0;
    for (int i = 0; i < cnt; i++) e[8*i +: 8] = q[i];
    chk("op", op, e);
    chk("op_cnt", 32'(op_cnt), 32'(cnt));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("pop_err", 32'(pop_err), 32'(m_err));
    chk("ram_cs", 32'(ram_cs), 32'(m_k != KIdle));
    if (m_k != KIdle) chk("ram_addr", 32'(ram_addr), 32'(m_bus));
    chk("data_ok", 32'(data_ok), 32'(m_dok));
    if (m_dok) chk("data_dout", 32'(data_dout), 32'(m_dout));
  endtask

  task automatic drive();
    int cnt;
    cen = ($urandom_range(99) < cen_pct);
    // RAM: answers the transaction the model believes is on the bus
    if (m_k != KIdle) begin
      if (wait_cnt == 0) begin
        ram_ok = 1'b1;
        ram_dout = mword(m_bus);
      end else begin
        wait_cnt--;
        ram_ok = 1'b0;
        ram_dout = 16'($urandom);
      end
    end else begin
      ram_ok = 1'b0;
      ram_dout = 16'($urandom);
      wait_cnt = $urandom_range(lat_max, lat_min);
    end
    // Operand requester: holds the request until data_ok
    if (m_dok) data_req = 1'b0;
    else if (!data_req) begin
      if (f_dreq) begin
        data_req = 1'b1; data_addr = f_daddr; f_dreq = 0;
      end else if ($urandom_range(99) < dreq_pct) begin
        data_req = 1'b1; data_addr = 24'($urandom);
      end
    end
    if (f_jmp) begin
      jmp_en = 1'b1; jmp_addr = f_jaddr; f_jmp = 0;
    end else begin
      jmp_en = ($urandom_range(99) < jmp_pct);
      jmp_addr = ($urandom_range(1) == 1) ? 24'($urandom) : 24'hFFFFF0 + 24'($urandom_range(15));
    end
    cnt = head_cnt();
    if (f_pop >= 0) begin
      pop = 3'(f_pop); f_pop = -1;
    end else if (pop_mode == 1) begin
      if ($urandom_range(99) < bad_pct) pop = 3'($urandom_range(7, cnt + 1));
      else pop = 3'($urandom_range(cnt));
    end else if (pop_mode == 2) begin
      pop = (cnt >= 2) ? 3'd2 : 3'd0;
    end else begin
      pop = 3'd0;
    end
  endtask

  // Advance the model by one enabled cycle using the inputs just driven
  task automatic model_step();
    int cnt, nk;
    bit popv, pushing;
    if (!cen) return;
    cnt = head_cnt();
    popv = (int'(pop) <= cnt);
    if (!popv) m_err = 1;
    pushing = (m_k == KFetch) && ram_ok && !jmp_en;
    if (jmp_en) begin
      q.delete();
      m_pc = jmp_addr;
      m_faddr = jmp_addr;
    end else begin
      if (popv) begin
        repeat (int'(pop)) void'(q.pop_front());
        m_pc = m_pc + 24'(pop);
      end
      if (pushing) begin
        if (m_faddr[0]) begin
          q.push_back(ram_dout[15:8]);
          m_faddr = m_faddr + 24'd1;
        end else begin
          q.push_back(ram_dout[7:0]);
          q.push_back(ram_dout[15:8]);
          m_faddr = m_faddr + 24'd2;
        end
      end
    end
    nk = m_k;
    if (m_k != KIdle) begin
      if (ram_ok) nk = KIdle;
      else if (jmp_en && m_k == KFetch) nk = KDisc;
    end else if (data_req && !m_dok) begin
      nk = KData;
      m_bus = {data_addr[23:1], 1'b0};
    end else if ((DEPTH - q.size()) >= (m_faddr[0] ? 1 : 2)) begin
      nk = KFetch;
      m_bus = {m_faddr[23:1], 1'b0};
    end
    if ((m_k == KData) && ram_ok) m_dout = ram_dout;
    m_dok = (m_k == KData) && ram_ok;
    m_k = nk;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    drive();
    model_step();
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cen = 1'b1; jmp_en = 1'b0; pop = 3'd0; data_req = 1'b0; ram_ok = 1'b0;
    f_jmp = 0; f_dreq = 0; f_pop = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_op", op, 32'h0);
    chk("rst_op_cnt", 32'(op_cnt), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ram_cs", 32'(ram_cs), 32'd0);
    chk("rst_pop_err", 32'(pop_err), 32'd0);
    chk("rst_data_ok", 32'(data_ok), 32'd0);
    rst = 1'b0;
    wait_cnt = $urandom_range(lat_max, lat_min);
    model_step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] mp;

    // First fill: words 2211 and 4433 from address 0
    cen_pct = 100; lat_min = 0; lat_max = 0; pop_mode = 0;
    do_reset();
    for (int n = 0; n < 20 && q.size() < 4; n++) tick();
    mp = {q[3], q[2], q[1], q[0]};
    chk("model_first_op", mp, 32'h44332211);
    sample();
    chk("first_op", op, 32'h44332211);
    chk("first_op_cnt", 32'(op_cnt), 32'd4);
    chk("first_pc", 32'(pc), 32'h0);

    // Full ring keeps the bus quiet until a pop frees room
    for (int n = 0; n < 40 && q.size() < DEPTH; n++) tick();
    repeat (3) tick();
    sample();
    chk("full_ram_cs", 32'(ram_cs), 32'd0);
    chk("full_op_cnt", 32'(op_cnt), 32'd4);
    f_pop = 2;
    tick();
    sample();
    chk("refill_ram_cs", 32'(ram_cs), 32'd1);
    chk("refill_ram_addr", 32'(ram_addr), 32'h8);
    chk("refill_pc", 32'(pc), 32'h2);

    // Jump to an odd address while a prefetch is in flight
    lat_min = 2; lat_max = 2;
    do_reset();
    f_jmp = 1; f_jaddr = 24'h000101;
    tick();
    for (int n = 0; n < 30 && q.size() == 0; n++) tick();
    sample();
    chk("jmp_op_cnt", 32'(op_cnt), 32'd1);
    chk("jmp_pc", 32'(pc), 32'h101);
    chk("jmp_op", op, 32'h00000023);

    // Over-pop is ignored and latches pop_err
    f_pop = 3;
    tick();
    sample();
    chk("overpop_err", 32'(pop_err), 32'd1);
    chk("overpop_pc", 32'(pc), 32'h101);
    chk("overpop_cnt", 32'(op_cnt), 32'd1);
    repeat (6) tick();
    sample();
    chk("overpop_sticky", 32'(pop_err), 32'd1);

    // Fetch across the top of the address space
    lat_min = 0; lat_max = 0;
    do_reset();
    f_jmp = 1; f_jaddr = 24'hFFFFFE;
    for (int n = 0; n < 30 && (f_jmp || q.size() < 4); n++) tick();
    sample();
    chk("wrap_op", op, 32'h221100EF);
    chk("wrap_pc", 32'(pc), 32'hFFFFFE);

    // Operand read arriving during a prefetch waits for it
    lat_min = 1; lat_max = 1;
    do_reset();
    f_dreq = 1; f_daddr = 24'h001235;
    for (int n = 0; n < 20 && m_k != KData; n++) tick();
    sample();
    chk("dread_ram_cs", 32'(ram_cs), 32'd1);
    chk("dread_ram_addr", 32'(ram_addr), 32'h001234);
    chk("dread_after_fetch", 32'(op_cnt), 32'd2);
    for (int n = 0; n < 20 && !m_dok; n++) tick();
    sample();
    chk("dread_ok", 32'(data_ok), 32'd1);
    chk("dread_dout", 32'(data_dout), 32'h8497);

    // Randomised traffic
    cen_pct = 75; lat_min = 0; lat_max = 3; jmp_pct = 3; dreq_pct = 8; bad_pct = 1;
    pop_mode = 1;
    do_reset();
    repeat (4000) tick();

    // Steady two-byte consumption with a zero-latency bus
    cen_pct = 100; lat_min = 0; lat_max = 0; jmp_pct = 0; dreq_pct = 0; bad_pct = 0;
    pop_mode = 2;
    do_reset();
    repeat (300) tick();
    sample();
    chk("steady_pop_err", 32'(pop_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
